des_sbox_sequencer: RTL and testbench
=====================================

# des_sbox_sequencer

Serial controller that drives one shared DES S-box bank (S1..S8, raw 6-bit index in, 4-bit value out, combinational) to evaluate the full 48→32-bit S-box layer of the f-function. It accepts a 48-bit word (expanded R XOR subkey) over a valid/ready handshake and issues eight lookups, one per cycle, S1 first. It then presents the packed 32-bit result over a second valid/ready handshake. It sits between the key-mix XOR and the P permutation in the area-reduced round datapath.

## Interface
Parameters: none (widths fixed by DES).
- clk  in  1  sole clock; all state updates on rising edge
- rst  in  1  reset, synchronous and active-high
- in_valid  in  1  in_data is offered
- in_ready  out  1  block can accept in_data this cycle
- in_data  in  [48:1]  S-box layer input; in_data[48:43] feeds S1 … in_data[6:1] feeds S8
- out_valid  out  1  out_data holds a completed result
- out_ready  in  1  consumer takes out_data this cycle
- out_data  out  [32:1]  packed result; S1 at [32:29] … S8 at [4:1]
- busy  out  1  high in RUN or DONE
- sbox_sel  out  [3:1]  S-box select to bank: 0 = S1 … 7 = S8
- sbox_in  out  [6:1]  raw 6-bit index to the selected S-box (row/column decode is inside the bank)
- sbox_out  in  [4:1]  bank result for (sbox_sel, sbox_in), same cycle

## Operation
- States: IDLE, RUN, DONE. in_ready = (state==IDLE); out_valid = (state==DONE); busy = !IDLE.
- IDLE: on in_valid, load in_data into 48-bit shift register src, clear 3-bit counter cnt, clear 32-bit accumulator acc, go RUN. Without in_valid, stay.
- RUN: sbox_sel = cnt, sbox_in = src[48:43]. Each cycle: acc <= {acc[28:1], sbox_out}, src <= src << 6, cnt <= cnt+1. When cnt==7: out_data <= {acc[28:1], sbox_out}, go DONE. cnt wraps 7→0 and is not otherwise used.
- DONE: hold out_data; on out_ready go IDLE; otherwise hold indefinitely.
- Outside RUN, sbox_sel = 0 and sbox_in = 0, deterministic, never X.
- out_data changes only on the RUN→DONE transition and on reset. It keeps its value after the output handshake.
- in_valid is ignored outside IDLE. in_data must be held only during the accepting cycle.
- Reset, applied at any time including mid-RUN or in DONE: next state IDLE, cnt=0, src=0, acc=0, out_data=0. Any in-flight word is dropped with no out_valid. in_valid is ignored in a cycle where rst=1.
- Reset values after the first rst edge: in_ready=1, out_valid=0, busy=0, out_data=0, sbox_sel=0, sbox_in=0.

## Timing
- Accept at edge ending cycle T, where IDLE and in_valid=1.
- RUN occupies cycles T+1..T+8, with sbox_sel = 0..7 in order.
- out_valid is high from cycle T+9.
- Minimum period is 10 cycles per word: IDLE accept, then 8 RUN, then 1 DONE with out_ready=1.
- No overlap: a new word cannot be accepted in the cycle out_ready completes DONE. in_ready rises the following cycle.
- sbox_out is sampled at the same edge that advances cnt. The bank path is combinational and lies within one cycle.
- Timing is data-independent. The schedule has no early exit.

## Test plan
- Reset then in_data=48'h0 with the real S-box bank, out_ready=1 → sbox_sel walks 0..7, sbox_in=0 each step; out_valid at T+9 with out_data=32'hEFA72C4D; in_ready returns one cycle after DONE.
- in_data=48'h000000000001 → sbox_in is 0 for S1..S7 and 1 for S8; out_data=32'hEFA72C41.
- Backpressure: out_ready=0 for 5 cycles in DONE → out_valid and out_data stable, in_ready=0, in_valid pulses ignored; out_ready=1 → IDLE next cycle.
- rst=1 in the 4th RUN cycle → next cycle IDLE, in_ready=1, out_data=0, no out_valid. A following word completes normally with correct data.
- Back-to-back: in_valid held high with two words, out_ready=1 → second word accepted exactly 10 cycles after the first; both results correct and unaffected by each other.
- in_valid and rst asserted in the same cycle → word not accepted, block remains IDLE.

Source files
------------

// File: rtl/des_sbox_if.sv
// Valid/ready bundle for the S-box layer: 48-bit word in, packed 32-bit result out.
interface des_sbox_if;
   logic        in_valid;
   logic        in_ready;
   logic [48:1] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [32:1] out_data;

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );
endinterface

// File: rtl/des_sbox_sequencer.sv
// Serialises the DES 48->32 S-box layer over one shared combinational S-box bank.
// state | meaning
// IDLE  | waiting for a word; in_ready high
// RUN   | one lookup per cycle, S1..S8, cnt selects the box
// DONE  | result held on out_data until out_ready
module des_sbox_sequencer (
   input  logic             clk,
   input  logic             rst,
   des_sbox_if.slave        bus,
   output logic             busy,
   output logic [3:1]       sbox_sel,
   output logic [6:1]       sbox_in,
   input  logic [4:1]       sbox_out
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [48:1] src_q, src_d;
   logic [2:0]  cnt_q, cnt_d;
   logic [32:1] acc_q, acc_d;
   logic [32:1] out_data_q, out_data_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         src_q      <= '0;
         cnt_q      <= '0;
         acc_q      <= '0;
         out_data_q <= '0;
      end else begin
         state_q    <= state_d;
         src_q      <= src_d;
         cnt_q      <= cnt_d;
         acc_q      <= acc_d;
         out_data_q <= out_data_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      src_d      = src_q;
      cnt_d      = cnt_q;
      acc_d      = acc_q;
      out_data_d = out_data_q;
      sbox_sel   = '0;
      sbox_in    = '0;
      case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               src_d   = bus.in_data;
               cnt_d   = '0;
               acc_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            sbox_sel = cnt_q;
            sbox_in  = src_q[48:43];
            // Bank result is captured on the same edge that advances cnt.
            acc_d    = {acc_q[28:1], sbox_out};
            src_d    = {src_q[42:1], 6'b0};
            cnt_d    = cnt_q + 3'd1;
            if (cnt_q == 3'd7) begin
               out_data_d = {acc_q[28:1], sbox_out};
               state_d    = ST_DONE;
            end
         end
         ST_DONE: begin
            if (bus.out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign bus.in_ready  = (state_q == ST_IDLE);
   assign bus.out_valid = (state_q == ST_DONE);
   assign bus.out_data  = out_data_q;
   assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_des_sbox_sequencer.sv
// Bench for des_sbox_sequencer: real DES S-box bank, directed words, queue scoreboard.
module tb_des_sbox_sequencer;

   // Row-major S-box tables, row 0 column 0 in the top nibble.
   localparam logic [255:0] SB_TBL [0:7] = '{
      256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
      256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
      256'hA09E63F51DC7B428_D70934A6285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
      256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
      256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
      256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
      256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
      256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
   };

   logic       clk = 1'b0;
   logic       rst;
   logic       busy;
   logic [2:0] sbox_sel;
   logic [5:0] sbox_in;
   logic [3:0] sbox_out;

   des_sbox_if bus ();

   des_sbox_sequencer dut (
      .clk      (clk),
      .rst      (rst),
      .bus      (bus.slave),
      .busy     (busy),
      .sbox_sel (sbox_sel),
      .sbox_in  (sbox_in),
      .sbox_out (sbox_out)
   );

   always #5 clk = ~clk;

   always_comb begin
      logic [255:0] row_bits;
      int           k;
      row_bits = SB_TBL[sbox_sel];
      k        = {26'd0, sbox_in[5], sbox_in[0], sbox_in[4:1]};
      sbox_out = 4'(row_bits >> (4 * (63 - k)));
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_q [$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   // Monitor: every output handshake is matched against the scoreboard.
   always @(negedge clk) begin
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_out_valid", 64'(bus.out_data), 64'hDEAD);
         end else begin
            chk("out_data", 64'(bus.out_data), 64'(exp_q.pop_front()));
            chk("in_ready_in_done", 64'(bus.in_ready), 64'd0);
         end
      end
   end

   task automatic wait_ready();
      int t = 0;
      while (bus.in_ready !== 1'b1 && t < 50) begin
         @(negedge clk);
         t++;
      end
      if (bus.in_ready !== 1'b1) chk("in_ready_timeout", 64'(bus.in_ready), 64'd1);
   endtask

   // Issues one word, then checks the lookup walk and out_valid at T+9.
   task automatic send(input logic [48:1] w, input logic [32:1] e);
      logic [48:1] wv;
      wv = w;
      wait_ready();
      bus.in_valid = 1'b1;
      bus.in_data  = w;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      exp_q.push_back(e);
      for (int k = 0; k < 8; k++) begin
         chk("sbox_sel", 64'(sbox_sel), 64'(k));
         chk("sbox_in", 64'(sbox_in), 64'(wv[48-6*k -: 6]));
         @(negedge clk);
      end
      chk("out_valid_t9", 64'(bus.out_valid), 64'd1);
   endtask

   task automatic drain();
      int t = 0;
      while (exp_q.size() != 0 && t < 50) begin
         @(negedge clk);
         t++;
      end
      chk("drain_timeout", 64'(exp_q.size()), 64'd0);
   endtask

   initial begin
      logic [48:1] w2 [0:1];
      logic [32:1] e2 [0:1];
      int          stamp [0:1];
      int          n;

      rst           = 1'b1;
      bus.in_valid  = 1'b1;
      bus.in_data   = 48'hFFFFFFFFFFFF;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
      chk("rst_busy", 64'(busy), 64'd0);
      rst          = 1'b0;
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      @(negedge clk);
      chk("rst_still_idle", 64'(bus.in_ready), 64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'd0);
      chk("rst_sbox_sel", 64'(sbox_sel), 64'd0);
      chk("rst_sbox_in", 64'(sbox_in), 64'd0);

      send(48'h000000000000, 32'hEFA72C4D);
      @(negedge clk);
      chk("post_done_in_ready", 64'(bus.in_ready), 64'd1);
      chk("post_done_out_valid", 64'(bus.out_valid), 64'd0);
      chk("post_done_out_data_kept", 64'(bus.out_data), 64'hEFA72C4D);
      chk("idle_sbox_sel", 64'(sbox_sel), 64'd0);

      send(48'h000000000001, 32'hEFA72C41);
      send(48'hFFFFFFFFFFFF, 32'hD9CE3DCB);
      send(48'h082082082082, 32'h410DC1B2);
      send(48'hFC0000000000, 32'hDFA72C4D);
      @(negedge clk);

      // Backpressure in DONE with ignored in_valid pulses.
      bus.out_ready = 1'b0;
      send(48'h082082082082, 32'h410DC1B2);
      for (int i = 0; i < 5; i++) begin
         chk("bp_out_valid", 64'(bus.out_valid), 64'd1);
         chk("bp_out_data", 64'(bus.out_data), 64'h410DC1B2);
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         bus.in_valid = i[0];
         bus.in_data  = 48'hFFFFFFFFFFFF;
         @(negedge clk);
      end
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_release_in_ready", 64'(bus.in_ready), 64'd1);
      chk("bp_release_out_valid", 64'(bus.out_valid), 64'd0);
      chk("bp_queue_empty", 64'(exp_q.size()), 64'd0);

      // Reset during the 4th RUN cycle drops the word.
      bus.in_valid = 1'b1;
      bus.in_data  = 48'hFFFFFFFFFFFF;
      @(negedge clk);
      bus.in_valid = 1'b0;
      bus.in_data  = '0;
      repeat (3) @(negedge clk);
      chk("abort_sel_cnt3", 64'(sbox_sel), 64'd3);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_in_ready", 64'(bus.in_ready), 64'd1);
      chk("abort_out_valid", 64'(bus.out_valid), 64'd0);
      chk("abort_out_data", 64'(bus.out_data), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      repeat (12) begin
         @(negedge clk);
         chk("abort_no_out_valid", 64'(bus.out_valid), 64'd0);
      end
      send(48'h000000000001, 32'hEFA72C41);
      @(negedge clk);

      // Back-to-back with in_valid held high across both words.
      w2[0] = 48'h000000000000; e2[0] = 32'hEFA72C4D;
      w2[1] = 48'hFFFFFFFFFFFF; e2[1] = 32'hD9CE3DCB;
      stamp[0] = 0;
      stamp[1] = 0;
      n = 0;
      bus.in_valid = 1'b1;
      bus.in_data  = w2[0];
      for (int i = 0; i < 40 && n < 2; i++) begin
         if (bus.in_ready === 1'b1) begin
            stamp[n] = cyc;
            exp_q.push_back(e2[n]);
            n++;
         end
         @(negedge clk);
         if (n < 2) bus.in_data = w2[n];
         else begin
            bus.in_valid = 1'b0;
            bus.in_data  = '0;
         end
      end
      bus.in_valid = 1'b0;
      chk("b2b_accepts", 64'(n), 64'd2);
      chk("b2b_spacing", 64'(stamp[1] - stamp[0]), 64'd10);
      drain();
      repeat (3) @(negedge clk);
      chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
